// File: rtl/tape_reader_dev.sv
// Paper-tape reader emulator: buffers 5-bit tape codes from a host and presents them
// one at a time to the core's input port, with a fixed gap after each transfer.
module tape_reader_dev #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHAR_GAP = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     host_wr_en,
    input  logic [4:0]               host_wr_data,
    input  logic                     host_clear,
    output logic                     host_full,
    output logic                     host_overflow,
    output logic [$clog2(DEPTH):0]   tape_count,
    output logic                     tape_empty,
    input  logic                     dev_input_rdy,
    output logic                     dev_input_val,
    output logic [4:0]               dev_input_data,
    output logic [15:0]              chars_sent
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;

    typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            val_q, val_d;
    logic [4:0]      data_q, data_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q;
    logic [15:0]     sent_q;
    logic [4:0]      mem [DEPTH];

    logic full, xfer, push, pop, drop;
    logic [4:0] head;

    assign full = (count_q == CW'(DEPTH));
    assign head = mem[rd_ptr_q];

    // A clear cancels any handshake that coincides with it.
    assign xfer = val_q && dev_input_rdy && !host_clear;
    assign pop  = xfer;
    // A pop frees the slot in the same cycle, so a write at full is still accepted then.
    assign push = host_wr_en && !host_clear && (!full || pop);
    assign drop = host_wr_en && !host_clear && full && !pop;

    assign count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        val_d   = val_q;
        data_d  = data_q;
        if (host_clear) begin
            state_d = StIdle;
            val_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    val_d = 1'b0;
                    if (count_q != '0) begin
                        state_d = StPresent;
                        val_d   = 1'b1;
                        data_d  = head;
                    end
                end
                StPresent: begin
                    if (xfer) begin
                        state_d = StGap;
                        val_d   = 1'b0;
                        gap_d   = GW'(CHAR_GAP - 1);
                    end
                end
                StGap: begin
                    val_d = 1'b0;
                    if (gap_q == '0) begin
                        if (count_q != '0) begin
                            state_d = StPresent;
                            val_d   = 1'b1;
                            data_d  = head;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    val_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            gap_q      <= '0;
            val_q      <= 1'b0;
            data_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sent_q     <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            val_q   <= val_d;
            data_q  <= data_d;
            if (xfer) begin
                sent_q <= sent_q + 16'd1;
            end
            if (host_clear) begin
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_d;
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr_q] <= host_wr_data;
        end
    end

    assign host_full      = full;
    assign host_overflow  = overflow_q;
    assign tape_count     = count_q;
    assign tape_empty     = (count_q == '0);
    assign dev_input_val  = val_q;
    assign dev_input_data = data_q;
    assign chars_sent     = sent_q;

endmodule

// File: tb/tb_tape_reader_dev.sv
// Directed bench for tape_reader_dev: FIFO fill/drain, pacing, backpressure,
// overflow, clear and reset behaviour.
module tb_tape_reader_dev;

    logic        clk;
    logic        resetn;
    logic        host_wr_en;
    logic [4:0]  host_wr_data;
    logic        host_clear;
    logic        host_full;
    logic        host_overflow;
    logic [4:0]  tape_count;
    logic        tape_empty;
    logic        dev_input_rdy;
    logic        dev_input_val;
    logic [4:0]  dev_input_data;
    logic [15:0] chars_sent;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] got [32];
    int         got_cyc [32];
    int         got_n;

    tape_reader_dev #(
        .DEPTH    (16),
        .CHAR_GAP (4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .host_wr_en     (host_wr_en),
        .host_wr_data   (host_wr_data),
        .host_clear     (host_clear),
        .host_full      (host_full),
        .host_overflow  (host_overflow),
        .tape_count     (tape_count),
        .tape_empty     (tape_empty),
        .dev_input_rdy  (dev_input_rdy),
        .dev_input_val  (dev_input_val),
        .dev_input_data (dev_input_data),
        .chars_sent     (chars_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dev_input_rdy = 1'b0;
        host_wr_en    = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_val(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (dev_input_val) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Hold rdy high and record up to n transfers with their cycle offsets.
    task automatic collect(input int n, input int bound);
        got_n = 0;
        dev_input_rdy = 1'b1;
        for (int c = 0; c < bound && got_n < n; c++) begin
            if (dev_input_val) begin
                got[got_n]     = dev_input_data;
                got_cyc[got_n] = c;
                got_n++;
            end
            tick();
        end
        dev_input_rdy = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_tests++;
        if (dev_input_val !== 1'b0 || dev_input_data !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_dev: val=%0b data=%0h want 0/0", dev_input_val, dev_input_data);
        end
        n_tests++;
        if (tape_count !== 5'd0 || tape_empty !== 1'b1 || host_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo: count=%0d empty=%0b full=%0b want 0/1/0",
                     tape_count, tape_empty, host_full);
        end
        n_tests++;
        if (chars_sent !== 16'd0 || host_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stat: sent=%0d ovf=%0b want 0/0", chars_sent, host_overflow);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        dev_input_rdy = 1'b1;
        host_wr_en    = 1'b1;
        host_wr_data  = 5'h13;
        tick();
        host_wr_en = 1'b0;
        n_tests++;
        if (tape_count !== 5'd1 || dev_input_val !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: count=%0d val=%0b want 1/0", tape_count, dev_input_val);
        end
        tick();
        n_tests++;
        if (dev_input_val !== 1'b1 || dev_input_data !== 5'h13) begin
            n_fail++;
            $display("FAIL single_t2: val=%0b data=%0h want 1/13", dev_input_val, dev_input_data);
        end
        tick();
        n_tests++;
        if (chars_sent !== 16'd1 || tape_count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_sent: sent=%0d count=%0d want 1/0", chars_sent, tape_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dev_input_val !== 1'b0) begin
                n_fail++;
                $display("FAIL single_gap%0d: val=%0b want 0", i, dev_input_val);
            end
            tick();
        end
        n_tests++;
        if (tape_empty !== 1'b1 || dev_input_val !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: empty=%0b val=%0b want 1/0", tape_empty, dev_input_val);
        end
        dev_input_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        idle(6);
        for (int i = 1; i <= 3; i++) begin
            host_wr_en   = 1'b1;
            host_wr_data = 5'(i);
            tick();
        end
        host_wr_en = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (dev_input_val !== 1'b1 || dev_input_data !== 5'h01) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles want 0", bad);
        end
        collect(3, 60);
        n_tests++;
        if (got_n != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d transfers want 3", got_n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (got[i] !== 5'(i + 1)) begin
                    n_fail++;
                    $display("FAIL bp_data%0d: got %0h want %0h", i, got[i], i + 1);
                end
            end
            n_tests++;
            if (got_cyc[1] - got_cyc[0] != 5 || got_cyc[2] - got_cyc[1] != 5) begin
                n_fail++;
                $display("FAIL bp_spacing: got %0d,%0d want 5,5",
                         got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]);
            end
        end
        n_tests++;
        if (chars_sent !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_sent: got %0d want 4", chars_sent);
        end
    endtask

    task automatic test_full_overflow();
        idle(6);
        for (int i = 0; i <= 16; i++) begin
            if (i == 16) begin
                n_tests++;
                if (host_full !== 1'b1 || tape_count !== 5'd16 || host_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_16: full=%0b count=%0d ovf=%0b want 1/16/0",
                             host_full, tape_count, host_overflow);
                end
            end
            host_wr_en   = 1'b1;
            host_wr_data = 5'(i);
            tick();
        end
        host_wr_en = 1'b0;
        n_tests++;
        if (host_overflow !== 1'b1 || tape_count !== 5'd16 || host_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ovf: ovf=%0b count=%0d full=%0b want 1/16/1",
                     host_overflow, tape_count, host_full);
        end
        collect(16, 200);
        n_tests++;
        if (got_n != 16) begin
            n_fail++;
            $display("FAIL full_drain_n: got %0d want 16", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            n_tests++;
            if (got[i] !== 5'(i)) begin
                n_fail++;
                $display("FAIL full_drain%0d: got %0h want %0h", i, got[i], i);
            end
        end
        idle(6);
        n_tests++;
        if (tape_empty !== 1'b1 || dev_input_val !== 1'b0 || host_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after: empty=%0b val=%0b ovf=%0b want 1/0/1",
                     tape_empty, dev_input_val, host_overflow);
        end
        n_tests++;
        if (chars_sent !== 16'd20) begin
            n_fail++;
            $display("FAIL full_sent: got %0d want 20", chars_sent);
        end
    endtask

    task automatic test_clear();
        bit ok;
        host_wr_en   = 1'b1;
        host_wr_data = 5'h05;
        tick();
        host_wr_en = 1'b0;
        wait_val(10, ok);
        n_tests++;
        if (!ok || dev_input_data !== 5'h05) begin
            n_fail++;
            $display("FAIL clr_present: ok=%0b data=%0h want 1/05", ok, dev_input_data);
        end
        host_clear    = 1'b1;
        dev_input_rdy = 1'b1;
        host_wr_en    = 1'b1;
        host_wr_data  = 5'h07;
        tick();
        host_clear    = 1'b0;
        dev_input_rdy = 1'b0;
        host_wr_en    = 1'b0;
        n_tests++;
        if (dev_input_val !== 1'b0 || tape_count !== 5'd0 || host_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_state: val=%0b count=%0d ovf=%0b want 0/0/0",
                     dev_input_val, tape_count, host_overflow);
        end
        n_tests++;
        if (chars_sent !== 16'd20) begin
            n_fail++;
            $display("FAIL clr_sent: got %0d want 20", chars_sent);
        end
        idle(3);
        n_tests++;
        if (dev_input_val !== 1'b0 || tape_count !== 5'd0) begin
            n_fail++;
            $display("FAIL clr_wrdrop: val=%0b count=%0d want 0/0", dev_input_val, tape_count);
        end
    endtask

    task automatic test_push_pop();
        idle(2);
        for (int i = 0; i < 16; i++) begin
            host_wr_en   = 1'b1;
            host_wr_data = 5'(i);
            tick();
        end
        host_wr_en = 1'b0;
        n_tests++;
        if (tape_count !== 5'd16 || dev_input_val !== 1'b1 || dev_input_data !== 5'h00) begin
            n_fail++;
            $display("FAIL pp_pre: count=%0d val=%0b data=%0h want 16/1/00",
                     tape_count, dev_input_val, dev_input_data);
        end
        dev_input_rdy = 1'b1;
        host_wr_en    = 1'b1;
        host_wr_data  = 5'h1F;
        tick();
        dev_input_rdy = 1'b0;
        host_wr_en    = 1'b0;
        n_tests++;
        if (tape_count !== 5'd16 || host_overflow !== 1'b0 || dev_input_val !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_post: count=%0d ovf=%0b val=%0b want 16/0/0",
                     tape_count, host_overflow, dev_input_val);
        end
        collect(16, 200);
        n_tests++;
        if (got_n != 16) begin
            n_fail++;
            $display("FAIL pp_drain_n: got %0d want 16", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            logic [4:0] exp;
            exp = (i == 15) ? 5'h1F : 5'(i + 1);
            n_tests++;
            if (got[i] !== exp) begin
                n_fail++;
                $display("FAIL pp_drain%0d: got %0h want %0h", i, got[i], exp);
            end
        end
        n_tests++;
        if (chars_sent !== 16'd37) begin
            n_fail++;
            $display("FAIL pp_sent: got %0d want 37", chars_sent);
        end
    endtask

    task automatic test_reset_mid_gap();
        bit ok;
        int bad;
        idle(6);
        for (int i = 0; i < 4; i++) begin
            host_wr_en   = 1'b1;
            host_wr_data = 5'(10 + i);
            tick();
        end
        host_wr_en = 1'b0;
        wait_val(10, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_present: val never rose, want 1");
        end
        dev_input_rdy = 1'b1;
        tick();
        dev_input_rdy = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        n_tests++;
        if (dev_input_val !== 1'b0 || dev_input_data !== 5'd0 || tape_count !== 5'd0 ||
            tape_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_out: val=%0b data=%0h count=%0d empty=%0b want 0/0/0/1",
                     dev_input_val, dev_input_data, tape_count, tape_empty);
        end
        n_tests++;
        if (chars_sent !== 16'd0 || host_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stat: sent=%0d ovf=%0b want 0/0", chars_sent, host_overflow);
        end
        resetn = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dev_input_val !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: %0d cycles with val want 0", bad);
        end
        host_wr_en   = 1'b1;
        host_wr_data = 5'h11;
        tick();
        host_wr_en = 1'b0;
        tick();
        n_tests++;
        if (dev_input_val !== 1'b1 || dev_input_data !== 5'h11) begin
            n_fail++;
            $display("FAIL rst_newchar: val=%0b data=%0h want 1/11", dev_input_val, dev_input_data);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        host_wr_en    = 1'b0;
        host_wr_data  = 5'd0;
        host_clear    = 1'b0;
        dev_input_rdy = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_overflow();
        test_clear();
        test_push_pop();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
